// File: rtl/ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: FSM state encoding and
// register-index constants.
package ctrl_pkg;

   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] X0 = '0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BUBBLE   = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on synchronous rst, increments by one when
// inc is high, and holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count qualifying cycles, sticking at the maximum value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard stall controller for the 5-stage core. Produces PC / IF/ID enables,
// IF/ID and ID/EXE flushes and a back-end freeze for load-use hazards, taken
// branches and data-memory waits. Outputs are Mealy so a stall lands in the
// same cycle as its hazard.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; all hazards evaluated
// BUBBLE   | one cycle after a load-use stall; load-use detection masked
// MEM_WAIT | back end frozen until dmem_ready returns
module hazard_stall_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] IF_ID_rs1,
   input  logic [REG_IDX_W-1:0] IF_ID_rs2,
   input  logic                 IF_ID_uses_rs2,
   input  logic [REG_IDX_W-1:0] ID_EXE_rd,
   input  logic                 ID_EXE_MemRead,
   input  logic                 EXE_MEM_MemAccess,
   input  logic                 dmem_ready,
   input  logic                 branch_taken,
   output logic                 PC_Write,
   output logic                 IF_ID_Write,
   output logic                 IF_ID_Flush,
   output logic                 ID_EXE_Flush,
   output logic                 pipe_freeze,
   output logic                 mem_timeout,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     bubble_count,
   output logic [CNT_W-1:0]     flush_count
);

   // A zero timeout disables the check; keep the counter at least one bit wide.
   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam bit TO_EN = (MEM_TIMEOUT != 0);

   state_t              state, state_nxt;
   logic                load_use;
   logic                freeze_req;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic                timeout_q;

   // Hazard detection; in MEM_WAIT the held MEM stage keeps requesting until ready.
   always_comb begin
      load_use = ID_EXE_MemRead && (ID_EXE_rd != X0) &&
                 ((ID_EXE_rd == IF_ID_rs1) ||
                  (IF_ID_uses_rs2 && (ID_EXE_rd == IF_ID_rs2)));
      if (state == MEM_WAIT) begin
         freeze_req = !dmem_ready;
      end else begin
         freeze_req = EXE_MEM_MemAccess && !dmem_ready;
      end
   end

   // Next state and pipeline controls: reset > memory wait > branch > load-use.
   always_comb begin
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EXE_Flush = 1'b0;
      pipe_freeze  = 1'b0;
      state_nxt    = RUN;
      if (rst) begin
         IF_ID_Flush  = 1'b1;
         ID_EXE_Flush = 1'b1;
      end else if (freeze_req) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         pipe_freeze = 1'b1;
         state_nxt   = MEM_WAIT;
      end else if (branch_taken) begin
         // Squashes the dependent instruction, so a coincident load-use is moot.
         IF_ID_Flush  = 1'b1;
         ID_EXE_Flush = 1'b1;
      end else if (load_use && (state != BUBBLE)) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EXE_Flush = 1'b1;
         state_nxt    = BUBBLE;
      end
   end

   // Wait counter counts frozen cycles, saturating at the timeout value.
   always_comb begin
      wait_nxt = '0;
      if (pipe_freeze) begin
         wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      end
   end

   // State, wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (TO_EN && pipe_freeze && (wait_nxt == WAIT_MAX)) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!PC_Write),
      .count (stall_cycles)
   );

   // A load-use bubble is the only case with ID_EXE_Flush but no IF_ID_Flush.
   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ID_EXE_Flush && !IF_ID_Flush),
      .count (bubble_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (IF_ID_Flush && !rst),
      .count (flush_count)
   );
`else
   assign stall_cycles = '0;
   assign bubble_count = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MEM_TIMEOUT=4). Directed vectors
// push hand-computed expectations; a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

   localparam logic [4:0] NRM = 5'b11000;  // {PC_Write,IF_ID_Write,IF_ID_Flush,ID_EXE_Flush,pipe_freeze}
   localparam logic [4:0] FRZ = 5'b00001;
   localparam logic [4:0] RSV = 5'b11110;
   localparam logic [4:0] LUS = 5'b00010;
   localparam logic [4:0] BRF = 5'b11110;

   typedef struct {
      logic [4:0]  ctl;
      logic        to;
      logic        chk;
      logic [31:0] st;
      logic [31:0] bu;
      logic [31:0] fl;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_EXE_rd;
   logic        IF_ID_uses_rs2, ID_EXE_MemRead, EXE_MEM_MemAccess, dmem_ready, branch_taken;
   logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EXE_Flush, pipe_freeze, mem_timeout;
   logic [31:0] stall_cycles, bubble_count, flush_count;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned acc_st = 0, acc_bu = 0, acc_fl = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .IF_ID_rs1         (IF_ID_rs1),
      .IF_ID_rs2         (IF_ID_rs2),
      .IF_ID_uses_rs2    (IF_ID_uses_rs2),
      .ID_EXE_rd         (ID_EXE_rd),
      .ID_EXE_MemRead    (ID_EXE_MemRead),
      .EXE_MEM_MemAccess (EXE_MEM_MemAccess),
      .dmem_ready        (dmem_ready),
      .branch_taken      (branch_taken),
      .PC_Write          (PC_Write),
      .IF_ID_Write       (IF_ID_Write),
      .IF_ID_Flush       (IF_ID_Flush),
      .ID_EXE_Flush      (ID_EXE_Flush),
      .pipe_freeze       (pipe_freeze),
      .mem_timeout       (mem_timeout),
      .stall_cycles      (stall_cycles),
      .bubble_count      (bubble_count),
      .flush_count       (flush_count)
   );

   task automatic cmp(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, what, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the hand-computed response.
   task automatic vec(input logic r, input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic ma, input logic rdy,
                      input logic br, input logic [4:0] ctl, input logic to, input logic chk,
                      input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; IF_ID_uses_rs2 = u2; ID_EXE_rd = rd;
      ID_EXE_MemRead = mr; EXE_MEM_MemAccess = ma; dmem_ready = rdy; branch_taken = br;
      e.ctl = ctl; e.to = to; e.chk = chk; e.name = nm;
`ifdef HAZARD_PERF_CNT_EN
      e.st = acc_st; e.bu = acc_bu; e.fl = acc_fl;
`else
      e.st = 0; e.bu = 0; e.fl = 0;
`endif
      sb.push_back(e);
      if (r) begin
         acc_st = 0; acc_bu = 0; acc_fl = 0;
      end else begin
         if (!ctl[4]) acc_st++;
         if (ctl == LUS) acc_bu++;
         if (ctl == BRF) acc_fl++;
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.name, "ctl", 32'({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EXE_Flush, pipe_freeze}), 32'(e.ctl));
            if (e.chk) begin
               cmp(e.name, "mem_timeout", 32'(mem_timeout), 32'(e.to));
               cmp(e.name, "stall_cycles", stall_cycles, e.st);
               cmp(e.name, "bubble_count", bubble_count, e.bu);
               cmp(e.name, "flush_count", flush_count, e.fl);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; IF_ID_rs1 = 0; IF_ID_rs2 = 0; IF_ID_uses_rs2 = 0; ID_EXE_rd = 0;
      ID_EXE_MemRead = 0; EXE_MEM_MemAccess = 0; dmem_ready = 1; branch_taken = 0;
      //  r rs1 rs2 u2 rd mr ma rdy br  ctl to chk
      vec(1, 0, 0, 0, 0, 0, 0, 1, 0, RSV, 0, 0, "reset0");
      vec(1, 0, 0, 0, 0, 0, 0, 1, 0, RSV, 0, 1, "reset1");
      vec(0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 1, "idle");
      vec(0, 5, 0, 0, 5, 1, 0, 1, 0, LUS, 0, 1, "lu_rs1");
      vec(0, 5, 0, 0, 5, 1, 0, 1, 0, NRM, 0, 1, "bubble_mask");
      vec(0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 1, "after_bubble");
      vec(0, 1, 7, 0, 7, 1, 0, 1, 0, NRM, 0, 1, "rs2_unused");
      vec(0, 1, 7, 1, 7, 1, 0, 1, 0, LUS, 0, 1, "lu_rs2");
      vec(0, 1, 7, 1, 7, 1, 0, 1, 1, BRF, 0, 1, "br_in_bubble");
      vec(0, 0, 0, 1, 0, 1, 0, 1, 0, NRM, 0, 1, "rd_x0");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 0, 1, "mw1");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 0, 1, "mw2");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 0, 1, "mw3");
      vec(0, 0, 0, 0, 0, 0, 1, 1, 0, NRM, 0, 1, "mw_release");
      vec(0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 1, "mw_after");
      vec(0, 5, 0, 0, 5, 1, 0, 1, 1, BRF, 0, 1, "br_over_lu");
      vec(0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 1, "no_bubble");
      vec(0, 5, 0, 0, 5, 1, 1, 0, 1, FRZ, 0, 1, "frz_over_br");
      vec(0, 5, 0, 0, 5, 1, 1, 0, 1, FRZ, 0, 1, "mw_ignores_br");
      vec(0, 5, 0, 0, 5, 1, 1, 1, 1, BRF, 0, 1, "release_br");
      vec(0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 1, "idle3");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 0, 1, "to_frz1");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 0, 1, "to_frz2");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 0, 1, "to_frz3");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 0, 1, "to_frz4");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 1, 1, "to_frz5");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 1, 1, "to_frz6");
      vec(0, 0, 0, 0, 0, 0, 1, 1, 0, NRM, 1, 1, "to_release");
      vec(0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 1, 1, "to_sticky");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 1, 1, "pre_rst_frz");
      vec(1, 0, 0, 0, 0, 0, 1, 0, 0, RSV, 0, 0, "rst_mid_frz");
      vec(0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 1, "post_rst");
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 0, 1, "frz_after_rst");
      vec(0, 0, 0, 0, 0, 0, 1, 1, 0, NRM, 0, 1, "release_after_rst");
      vec(0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 0, 1, "final_idle");
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
